// File: rtl/adc_frame_streamer.sv
// adc_frame_streamer
//   Converts raw ADC codes to left-justified signed samples and stores them in
//   an FFT_LENGTH-deep ring. It then bursts overlapping frames (a new frame
//   start every HOP samples) to the FFT input.
//
//   Ports:
//     clk, reset        single clock, synchronous active-high reset
//     enable            run control; low clears fill/hop/due/state, aborts stream
//     adc_data[_valid]  raw ADC code plus one-cycle qualifier
//     frame_ready_i     downstream can take a frame start this cycle
//     sample_o/_valid_o frame sample stream, oldest sample first
//     frame_start_o     first sample of a frame
//     frame_last_o      last sample of a frame
//     overrun_o         sticky: a hop completed while a frame was already pending
//     frame_count_o     completed frames, wraps at 2^16
//
//   FFT_LENGTH must be a power of two and at least 2.
module adc_frame_streamer #(
   parameter int ADC_WIDTH   = 12,
   parameter int OUT_WIDTH   = 16,
   parameter int FFT_LENGTH  = 1024,
   parameter int HOP         = 512,
   parameter int SIGNED_MODE = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [ADC_WIDTH-1:0] adc_data,
   input  logic                 adc_data_valid,
   input  logic                 frame_ready_i,
   output logic [OUT_WIDTH-1:0] sample_o,
   output logic                 sample_valid_o,
   output logic                 frame_start_o,
   output logic                 frame_last_o,
   output logic                 overrun_o,
   output logic [15:0]          frame_count_o
);

   localparam int AW = $clog2(FFT_LENGTH);
   localparam int CW = $clog2(FFT_LENGTH + 1);
   localparam int HW = $clog2(HOP + 1);
   // Offset-binary to two's complement is a flip of the MSB.
   localparam logic [ADC_WIDTH-1:0] MSB_FLIP =
      (SIGNED_MODE != 0) ? '0 : (ADC_WIDTH'(1) << (ADC_WIDTH - 1));

   typedef enum logic [1:0] {FILL, ARMED, STREAM} state_t;

   state_t                 state, state_nx;
   logic [OUT_WIDTH-1:0]   mem [FFT_LENGTH];
   logic [AW-1:0]          wr_ptr, rd_ptr, start_addr;
   logic [CW-1:0]          fill_cnt, rd_cnt;
   logic [HW-1:0]          hop_cnt;
   logic                   due, due_nx, ovr_set;
   logic                   accept, fill_done, hop_done, consume, last_beat;
   logic [ADC_WIDTH-1:0]   code_tc;
   logic [OUT_WIDTH-1:0]   sample_conv;

   assign code_tc     = adc_data ^ MSB_FLIP;
   assign sample_conv = OUT_WIDTH'(code_tc) << (OUT_WIDTH - ADC_WIDTH);

   assign accept    = enable && adc_data_valid;
   assign fill_done = (state == FILL) && accept && (fill_cnt == CW'(FFT_LENGTH - 1));
   assign hop_done  = (state != FILL) && accept && (hop_cnt == HW'(HOP - 1));
   assign consume   = (state == ARMED) && due && frame_ready_i;
   assign last_beat = (state == STREAM) && (rd_cnt == CW'(FFT_LENGTH - 1));
   // Oldest sample: if a write lands this cycle it overwrites wr_ptr, so the
   // oldest surviving sample sits one slot further on.
   assign start_addr = accept ? (wr_ptr + AW'(1)) : wr_ptr;

   always_comb begin
      state_nx = state;
      due_nx   = due;
      ovr_set  = 1'b0;
      if (!enable) begin
         state_nx = FILL;
         due_nx   = 1'b0;
      end else begin
         case (state)
            FILL:    if (fill_done) begin
                        state_nx = ARMED;
                        due_nx   = 1'b1;
                     end
            ARMED:   if (consume) state_nx = STREAM;
            STREAM:  if (last_beat) state_nx = ARMED;
            default: state_nx = FILL;
         endcase
         // A hop landing on the consume cycle re-arms without overrun.
         if (hop_done) begin
            due_nx  = 1'b1;
            ovr_set = due && !consume;
         end else if (consume) begin
            due_nx = 1'b0;
         end
      end
   end

   // Ring storage; the registered read below sees pre-write contents.
   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= sample_conv;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= FILL;
         due            <= 1'b0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         fill_cnt       <= '0;
         hop_cnt        <= '0;
         rd_cnt         <= '0;
         sample_o       <= '0;
         sample_valid_o <= 1'b0;
         frame_start_o  <= 1'b0;
         frame_last_o   <= 1'b0;
         overrun_o      <= 1'b0;
         frame_count_o  <= '0;
      end else begin
         state          <= state_nx;
         due            <= due_nx;
         sample_valid_o <= 1'b0;
         frame_start_o  <= 1'b0;
         frame_last_o   <= 1'b0;
         if (ovr_set) overrun_o <= 1'b1;
         if (accept)  wr_ptr    <= wr_ptr + AW'(1);

         if (!enable || fill_done)            fill_cnt <= '0;
         else if (state == FILL && accept)    fill_cnt <= fill_cnt + CW'(1);

         if (!enable || fill_done || hop_done) hop_cnt <= '0;
         else if (state != FILL && accept)     hop_cnt <= hop_cnt + HW'(1);

         if (enable) begin
            if (consume) begin
               sample_o       <= mem[start_addr];
               sample_valid_o <= 1'b1;
               frame_start_o  <= 1'b1;
               rd_ptr         <= start_addr + AW'(1);
               rd_cnt         <= CW'(1);
            end else if (state == STREAM) begin
               sample_o       <= mem[rd_ptr];
               sample_valid_o <= 1'b1;
               rd_ptr         <= rd_ptr + AW'(1);
               rd_cnt         <= rd_cnt + CW'(1);
               if (last_beat) begin
                  frame_last_o  <= 1'b1;
                  frame_count_o <= frame_count_o + 16'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_adc_frame_streamer.sv
// Directed bench for adc_frame_streamer: a 16-deep/hop-8 offset-binary
// instance plus a 2-deep two's-complement instance for the signed conversion.
module tb_adc_frame_streamer;

   logic        clk = 1'b0;
   logic        reset, enable, frame_ready_i;
   logic [11:0] adc_data, adc_s;
   logic        adc_data_valid, adc_valid_s;
   logic [15:0] sample_o, sample_s, frame_count_o, fc_s;
   logic        sample_valid_o, frame_start_o, frame_last_o, overrun_o;
   logic        valid_s, start_s, last_s, ovr_s;

   int          vectors = 0;
   int          miscompares = 0;
   int          stray = 0;
   logic [15:0] exp_s [16];
   logic [15:0] exp_fc;

   always #5 clk = ~clk;

   adc_frame_streamer #(.ADC_WIDTH(12), .OUT_WIDTH(16), .FFT_LENGTH(16), .HOP(8), .SIGNED_MODE(0)) dut (
      .clk(clk), .reset(reset), .enable(enable), .adc_data(adc_data),
      .adc_data_valid(adc_data_valid), .frame_ready_i(frame_ready_i),
      .sample_o(sample_o), .sample_valid_o(sample_valid_o), .frame_start_o(frame_start_o),
      .frame_last_o(frame_last_o), .overrun_o(overrun_o), .frame_count_o(frame_count_o));

   adc_frame_streamer #(.ADC_WIDTH(12), .OUT_WIDTH(16), .FFT_LENGTH(2), .HOP(2), .SIGNED_MODE(1)) dut_s (
      .clk(clk), .reset(reset), .enable(enable), .adc_data(adc_s),
      .adc_data_valid(adc_valid_s), .frame_ready_i(frame_ready_i),
      .sample_o(sample_s), .sample_valid_o(valid_s), .frame_start_o(start_s),
      .frame_last_o(last_s), .overrun_o(ovr_s), .frame_count_o(fc_s));

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic feed(input logic [11:0] c);
      @(negedge clk);
      adc_data = c;
      adc_data_valid = 1'b1;
      @(negedge clk);
      adc_data_valid = 1'b0;
   endtask

   task automatic feed_s(input logic [11:0] c);
      @(negedge clk);
      adc_s = c;
      adc_valid_s = 1'b1;
      @(negedge clk);
      adc_valid_s = 1'b0;
   endtask

   // Idle cycles where no frame is expected; any valid seen is counted.
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         if (sample_valid_o) stray++;
      end
   endtask

   // Offset-binary code c < 0x800 maps to 0x8000 | (c << 4).
   task automatic set_ramp(input int base, input int fc);
      for (int i = 0; i < 16; i++) exp_s[i] = 16'h8000 | 16'((base + i) << 4);
      exp_fc = 16'(fc);
   endtask

   task automatic check_stray(input string name);
      vectors++;
      if (stray !== 0) begin
         miscompares++;
         $display("FAIL %s: got %0d stray valid cycles, expected 0", name, stray);
      end
      stray = 0;
   endtask

   // Expects the frame in exp_s to start one cycle after the current one.
   task automatic check_frame(input string name);
      int k = 0;
      while (!sample_valid_o && k < 8) begin
         @(negedge clk);
         k++;
      end
      vectors++;
      if (k !== 1) begin
         miscompares++;
         $display("FAIL %s latency: got %0d cycles, expected 1", name, k);
      end
      for (int i = 0; i < 16; i++) begin
         vectors++;
         if ({sample_valid_o, sample_o} !== {1'b1, exp_s[i]}) begin
            miscompares++;
            $display("FAIL %s beat %0d: got v=%b %h expected v=1 %h", name, i, sample_valid_o, sample_o, exp_s[i]);
         end
         vectors++;
         if ({frame_start_o, frame_last_o} !== {i == 0, i == 15}) begin
            miscompares++;
            $display("FAIL %s flags beat %0d: got start/last %b%b expected %b%b", name, i,
                     frame_start_o, frame_last_o, i == 0, i == 15);
         end
         if (i == 15) begin
            vectors++;
            if (frame_count_o !== exp_fc) begin
               miscompares++;
               $display("FAIL %s frame_count: got %0d expected %0d", name, frame_count_o, exp_fc);
            end
         end
         @(negedge clk);
      end
      vectors++;
      if (sample_valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL %s tail: got valid %b expected 0", name, sample_valid_o);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; frame_ready_i = 1'b1;
      adc_data = '0; adc_data_valid = 1'b0; adc_s = '0; adc_valid_s = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({sample_o, sample_valid_o, frame_start_o, frame_last_o, overrun_o, frame_count_o} !== 36'd0) begin
         miscompares++;
         $display("FAIL reset outputs: got %h/%b%b%b%b/%h expected all 0", sample_o, sample_valid_o,
                  frame_start_o, frame_last_o, overrun_o, frame_count_o);
      end
      reset = 1'b0;
   endtask

   task automatic test_conv_offset();
      do_reset();
      feed(12'h800); idle(20);
      feed(12'h000); idle(20);
      feed(12'hFFF); idle(20);
      for (int c = 1; c <= 12; c++) begin
         feed(12'(c)); idle(20);
      end
      feed(12'h00D);
      exp_s[0] = 16'h0000; exp_s[1] = 16'h8000; exp_s[2] = 16'h7FF0;
      for (int i = 3; i < 16; i++) exp_s[i] = 16'h8000 | 16'((i - 2) << 4);
      exp_fc = 16'd1;
      check_frame("conv_offset");
      check_stray("conv_offset quiet");
   endtask

   task automatic test_conv_signed();
      do_reset();
      feed_s(12'h800); idle(5);
      feed_s(12'h7FF);
      @(negedge clk);
      vectors++;
      if ({valid_s, sample_s, start_s, last_s} !== {1'b1, 16'h8000, 2'b10}) begin
         miscompares++;
         $display("FAIL conv_signed beat0: got v=%b %h %b%b expected v=1 8000 10", valid_s, sample_s, start_s, last_s);
      end
      @(negedge clk);
      vectors++;
      if ({valid_s, sample_s, start_s, last_s, fc_s} !== {1'b1, 16'h7FF0, 2'b01, 16'd1}) begin
         miscompares++;
         $display("FAIL conv_signed beat1: got v=%b %h %b%b fc=%0d expected v=1 7ff0 01 fc=1",
                  valid_s, sample_s, start_s, last_s, fc_s);
      end
      stray = 0;
   endtask

   task automatic test_first_frame();
      do_reset();
      for (int c = 0; c < 15; c++) begin
         feed(12'(c)); idle(20);
      end
      check_stray("first_frame quiet");
      feed(12'd15);
      set_ramp(0, 1);
      check_frame("first_frame");
   endtask

   task automatic test_overlap();
      for (int c = 16; c < 23; c++) begin
         feed(12'(c)); idle(20);
      end
      check_stray("overlap quiet");
      feed(12'd23);
      set_ramp(8, 2);
      check_frame("overlap");
      vectors++;
      if (overrun_o !== 1'b0) begin
         miscompares++;
         $display("FAIL overlap overrun: got %b expected 0", overrun_o);
      end
   endtask

   task automatic test_enable_drop();
      for (int c = 24; c < 31; c++) begin
         feed(12'(c)); idle(20);
      end
      feed(12'd31);
      @(negedge clk);
      repeat (4) @(negedge clk);
      vectors++;
      if ({sample_valid_o, sample_o} !== {1'b1, 16'h8140}) begin
         miscompares++;
         $display("FAIL enable_drop beat4: got v=%b %h expected v=1 8140", sample_valid_o, sample_o);
      end
      enable = 1'b0;
      @(negedge clk);
      vectors++;
      if ({sample_valid_o, frame_last_o, frame_count_o} !== {2'b00, 16'd2}) begin
         miscompares++;
         $display("FAIL enable_drop abort: got v=%b last=%b fc=%0d expected v=0 last=0 fc=2",
                  sample_valid_o, frame_last_o, frame_count_o);
      end
      idle(5);
      enable = 1'b1;
      for (int c = 100; c < 115; c++) begin
         feed(12'(c)); idle(20);
      end
      check_stray("enable_drop refill quiet");
      feed(12'd115);
      set_ramp(100, 3);
      check_frame("enable_refill");
   endtask

   task automatic test_backpressure();
      do_reset();
      frame_ready_i = 1'b0;
      for (int c = 0; c < 32; c++) begin
         feed(12'(c));
         if (c == 22) begin
            vectors++;
            if (overrun_o !== 1'b0) begin
               miscompares++;
               $display("FAIL backpressure early overrun: got %b expected 0", overrun_o);
            end
         end
         if (c == 23) begin
            vectors++;
            if (overrun_o !== 1'b1) begin
               miscompares++;
               $display("FAIL backpressure overrun: got %b expected 1", overrun_o);
            end
         end
         idle(20);
      end
      check_stray("backpressure held");
      frame_ready_i = 1'b1;
      set_ramp(16, 1);
      check_frame("backpressure");
      idle(30);
      for (int c = 32; c < 39; c++) begin
         feed(12'(c)); idle(20);
      end
      check_stray("backpressure single frame");
   endtask

   task automatic test_reset_mid();
      feed(12'd39);
      @(negedge clk);
      repeat (5) @(negedge clk);
      vectors++;
      if ({sample_valid_o, sample_o} !== {1'b1, 16'h81D0}) begin
         miscompares++;
         $display("FAIL reset_mid beat5: got v=%b %h expected v=1 81d0", sample_valid_o, sample_o);
      end
      reset = 1'b1;
      @(negedge clk);
      vectors++;
      if ({sample_o, sample_valid_o, frame_start_o, frame_last_o, overrun_o, frame_count_o} !== 36'd0) begin
         miscompares++;
         $display("FAIL reset_mid outputs: got %h/%b%b%b%b/%h expected all 0", sample_o, sample_valid_o,
                  frame_start_o, frame_last_o, overrun_o, frame_count_o);
      end
      reset = 1'b0;
      stray = 0;
      for (int c = 200; c < 215; c++) begin
         feed(12'(c)); idle(20);
      end
      check_stray("reset_mid refill quiet");
      feed(12'd215);
      set_ramp(200, 1);
      check_frame("reset_mid refill");
   endtask

   initial begin
      test_reset();
      test_conv_offset();
      test_conv_signed();
      test_first_frame();
      test_overlap();
      test_enable_drop();
      test_backpressure();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
